multi_channel_clock_divider: RTL

Parametrised successor to the single-LED clock converter: NUM_CH independent divider channels, each producing a one-cycle `tick` strobe and a 50 %-duty `wave` output from the one system clock. Each channel has a runtime-programmable divisor and an enable. A global `sync` re-phases all channels. It sits between the board clock and LED, display-scan and debounce logic, replacing fixed-ratio dividers.

---
 rtl/multi_channel_clock_divider_pkg.sv | 13 +
 rtl/multi_channel_clock_divider_divider_channel.sv | 72 +++++++
 rtl/multi_channel_clock_divider.sv | 66 ++++++
 3 files changed

// File: rtl/multi_channel_clock_divider_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
// A 100 MHz clock divided by DEFAULT_DIV_DEFAULT gives a 1 Hz wave.
package multi_channel_clock_divider_pkg;

    localparam int CNT_W_DEFAULT       = 26;
    localparam int DEFAULT_DIV_DEFAULT = 50_000_000;

    // Width of the channel index; a single-channel build still needs one bit.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_channel_clock_divider_divider_channel.sv
// One divider channel: a programmable divisor, an up-counter with a terminal compare,
// and registered tick/wave outputs.
module divider_channel
    import multi_channel_clock_divider_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_div,
    output logic             tick,
    output logic             wave
);

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             wave_q, wave_d;

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        wave_d = wave_q;

        if (en) begin
            if (cnt_q == div_q - CNT_W'(1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                wave_d = ~wave_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A divisor load beats a coincident terminal count; sync then clears the phase.
        if (ld) begin
            div_d  = ld_div;
            cnt_d  = '0;
            tick_d = 1'b0;
            wave_d = wave_q;
        end

        if (sync) begin
            cnt_d  = '0;
            tick_d = 1'b0;
            wave_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= CNT_W'(DEFAULT_DIV);
            cnt_q  <= '0;
            tick_q <= 1'b0;
            wave_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            wave_q <= wave_d;
        end
    end

    assign tick = tick_q;
    assign wave = wave_q;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent clock-divider channels with a shared divisor write port,
// write validation and a global re-phase strobe.
module multi_channel_clock_divider
    import multi_channel_clock_divider_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  CNT_W       = CNT_W_DEFAULT,
    parameter int  DEFAULT_DIV = DEFAULT_DIV_DEFAULT,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] wave
);

    logic ch_ok;
    logic div_ok;
    logic wr_ok;
    logic cfg_err_q, cfg_err_d;

    // Extra bit keeps the range check meaningful when NUM_CH is a power of two.
    assign ch_ok  = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
    assign div_ok = (cfg_div != '0);
    assign wr_ok  = cfg_we && ch_ok && div_ok;

    always_comb begin
        cfg_err_d = cfg_we && !(ch_ok && div_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ld;
        assign ld = wr_ok && (cfg_ch == CH_W'(i));

        divider_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en[i]),
            .sync   (sync),
            .ld     (ld),
            .ld_div (cfg_div),
            .tick   (tick[i]),
            .wave   (wave[i])
        );
    end

endmodule
